// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
// master = loader side, slave = stream source / memory side.
interface imem_loader_if;
   logic        byte_valid;
   logic [7:0]  byte_data;
   logic        byte_ready;
   logic [31:0] waddr;
   logic [31:0] data_in;
   logic        we;

   modport master (
      input  byte_valid, byte_data,
      output byte_ready, waddr, data_in, we
   );

   modport slave (
      output byte_valid, byte_data,
      input  byte_ready, waddr, data_in, we
   );
endinterface

// File: rtl/imem_loader.sv
// Boot-time program loader: framed byte stream (length, big-endian words, XOR checksum)
// into instruction-memory writes. The core is held in clear until a load succeeds.
module imem_loader #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int unsigned MAX_WORDS = 256,
   parameter int unsigned TIMEOUT   = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   imem_loader_if.master bus,
   output logic        cpu_hold,
   output logic        done,
   output logic        err,
   output logic [1:0]  err_code
);

   localparam int unsigned IW = $clog2(MAX_WORDS + 1);
   localparam int unsigned TW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_WRITE, S_CSUM, S_DONE, S_ERR
   } state_t;

   state_t          state, next_state;
   logic [15:0]     len;
   logic [15:0]     len_full;
   logic [IW-1:0]   widx;
   logic [1:0]      bidx;
   logic [23:0]     word;
   logic [7:0]      csum;
   logic [TW-1:0]   tcnt;
   logic            acc;
   logic            expired;
   logic            enter_len;

   assign acc       = bus.byte_valid && bus.byte_ready;
   assign len_full  = {len[15:8], bus.byte_data};
   assign expired   = bus.byte_ready && !acc && (tcnt == TW'(TIMEOUT - 1));
   assign enter_len = (next_state == S_LEN_HI) && (state != S_LEN_HI);

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         S_IDLE, S_DONE, S_ERR: if (start) next_state = S_LEN_HI;
         S_LEN_HI: if (acc) next_state = S_LEN_LO;
         S_LEN_LO: begin
            if (acc) begin
               if (32'(len_full) > MAX_WORDS) next_state = S_ERR;
               else if (len_full == '0)       next_state = S_CSUM;
               else                           next_state = S_DATA;
            end
         end
         S_DATA:  if (acc && bidx == 2'd3) next_state = S_WRITE;
         S_WRITE: next_state = (32'(widx) + 32'd1 == 32'(len)) ? S_CSUM : S_DATA;
         S_CSUM:  if (acc) next_state = (bus.byte_data == csum) ? S_DONE : S_ERR;
         default: next_state = S_IDLE;
      endcase
      // a stalled stream aborts the frame; any partial word is dropped
      if (expired) next_state = S_ERR;
   end

   always_comb begin
      bus.byte_ready = state inside {S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM};
      bus.we         = (state == S_WRITE);
      done           = (state == S_DONE);
      err            = (state == S_ERR);
      cpu_hold       = (state != S_DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         len         <= '0;
         widx        <= '0;
         bidx        <= '0;
         word        <= '0;
         csum        <= '0;
         tcnt        <= '0;
         err_code    <= 2'b00;
         bus.waddr   <= BASE_ADDR;
         bus.data_in <= '0;
      end else begin
         if (acc || enter_len)   tcnt <= '0;
         else if (bus.byte_ready) tcnt <= tcnt + TW'(1);

         case (state)
            S_IDLE, S_DONE, S_ERR: begin
               if (state == S_IDLE || start) begin
                  widx     <= '0;
                  bidx     <= '0;
                  csum     <= '0;
                  err_code <= 2'b00;
               end
            end
            S_LEN_HI: if (acc) len[15:8] <= bus.byte_data;
            S_LEN_LO: begin
               if (acc) begin
                  len[7:0] <= bus.byte_data;
                  if (32'(len_full) > MAX_WORDS) err_code <= 2'b01;
               end
            end
            S_DATA: begin
               if (acc) begin
                  word <= {word[15:0], bus.byte_data};
                  csum <= csum ^ bus.byte_data;
                  bidx <= bidx + 2'd1;
                  if (bidx == 2'd3) begin
                     bus.data_in <= {word, bus.byte_data};
                     bus.waddr   <= BASE_ADDR + (32'(widx) << 2);
                  end
               end
            end
            S_WRITE: widx <= widx + IW'(1);
            S_CSUM:  if (acc && bus.byte_data != csum) err_code <= 2'b10;
            default: ;
         endcase

         if (expired) err_code <= 2'b11;
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: two instances (base 0 and base 0x100) share one stream;
// expected writes are queued as bytes are driven and popped when we pulses.
module tb_imem_loader;
   logic       clk = 1'b0;
   logic       rst, start, valid;
   logic [7:0] data;
   logic       cpu_hold_a, done_a, err_a, cpu_hold_b, done_b, err_b;
   logic [1:0] err_code_a, err_code_b;

   imem_loader_if bus_a ();
   imem_loader_if bus_b ();

   assign bus_a.byte_valid = valid;
   assign bus_a.byte_data  = data;
   assign bus_b.byte_valid = valid;
   assign bus_b.byte_data  = data;

   imem_loader #(.BASE_ADDR(32'h0000_0000), .MAX_WORDS(256), .TIMEOUT(8)) dut_a (
      .clk(clk), .rst(rst), .start(start), .bus(bus_a),
      .cpu_hold(cpu_hold_a), .done(done_a), .err(err_a), .err_code(err_code_a)
   );

   imem_loader #(.BASE_ADDR(32'h0000_0100), .MAX_WORDS(256), .TIMEOUT(8)) dut_b (
      .clk(clk), .rst(rst), .start(start), .bus(bus_b),
      .cpu_hold(cpu_hold_b), .done(done_b), .err(err_b), .err_code(err_code_b)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   int          wcount = 0;
   logic [63:0] exp_a[$];
   logic [63:0] exp_b[$];
   logic [63:0] e_a, e_b;
   logic [31:0] words[8];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (bus_a.we === 1'b1) begin
         wcount++;
         check("ready_in_write", 32'(bus_a.byte_ready), 32'd0);
         if (exp_a.size() == 0) check("unexpected_we_a", 32'(exp_a.size()), 32'd1);
         else begin
            e_a = exp_a.pop_front();
            check("waddr_a", bus_a.waddr, e_a[63:32]);
            check("data_a", bus_a.data_in, e_a[31:0]);
         end
      end
      if (bus_b.we === 1'b1) begin
         if (exp_b.size() == 0) check("unexpected_we_b", 32'(exp_b.size()), 32'd1);
         else begin
            e_b = exp_b.pop_front();
            check("waddr_b", bus_b.waddr, e_b[63:32]);
            check("data_b", bus_b.data_in, e_b[31:0]);
         end
      end
   end

   // valid stays high after a byte; callers drop it when the stream should pause
   task automatic send_byte(input logic [7:0] b);
      int   n = 0;
      logic got = 1'b0;
      valid = 1'b1;
      data  = b;
      do begin
         @(negedge clk);
         got = bus_a.byte_ready;
         @(posedge clk);
         #1;
         n++;
      end while (!got && n < 40);
      if (!got) check("byte_accept_timeout", 32'(got), 32'd1);
   endtask

   task automatic send_frame(input int n, input logic [7:0] csum_flip, input logic pulse);
      logic [7:0]  cs;
      logic [15:0] len;
      logic [7:0]  b;
      cs  = '0;
      len = 16'(n);
      send_byte(len[15:8]);
      send_byte(len[7:0]);
      for (int i = 0; i < n; i++) begin
         exp_a.push_back({32'(4 * i), words[i]});
         exp_b.push_back({32'h100 + 32'(4 * i), words[i]});
         for (int k = 0; k < 4; k++) begin
            b     = words[i][31 - 8 * k -: 8];
            cs    = cs ^ b;
            start = pulse && (i == 0) && (k == 2);
            send_byte(b);
            start = 1'b0;
         end
         check("we_latency", 32'(bus_a.we), 32'd1);
      end
      send_byte(cs ^ csum_flip);
      valid = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ready"},    32'(bus_a.byte_ready), 32'd0);
      check({tag, "_we"},       32'(bus_a.we), 32'd0);
      check({tag, "_waddr_a"},  bus_a.waddr, 32'h0000_0000);
      check({tag, "_waddr_b"},  bus_b.waddr, 32'h0000_0100);
      check({tag, "_data_in"},  bus_a.data_in, 32'd0);
      check({tag, "_done"},     32'(done_a), 32'd0);
      check({tag, "_err"},      32'(err_a), 32'd0);
      check({tag, "_err_code"}, 32'(err_code_a), 32'd0);
      check({tag, "_cpu_hold"}, 32'(cpu_hold_a), 32'd1);
   endtask

   initial begin
      int w0;
      int n;
      rst   = 1'b1;
      start = 1'b0;
      valid = 1'b0;
      data  = '0;
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      rst = 1'b0;

      // basic two-word load
      words[0] = 32'h2008_0005;
      words[1] = 32'h0000_0008;
      pulse_start();
      send_frame(2, 8'h00, 1'b0);
      check("basic_done",     32'(done_a), 32'd1);
      check("basic_cpu_hold", 32'(cpu_hold_a), 32'd0);
      check("basic_err",      32'(err_a), 32'd0);
      check("basic_done_b",   32'(done_b), 32'd1);
      check("basic_pending",  32'(exp_a.size()), 32'd0);

      // checksum error: writes still happen
      pulse_start();
      check("restart_hold", 32'(cpu_hold_a), 32'd1);
      check("restart_done", 32'(done_a), 32'd0);
      send_frame(2, 8'h01, 1'b0);
      check("csum_err",      32'(err_a), 32'd1);
      check("csum_code",     32'(err_code_a), 32'd2);
      check("csum_cpu_hold", 32'(cpu_hold_a), 32'd1);
      check("csum_done",     32'(done_a), 32'd0);
      check("csum_pending",  32'(exp_a.size()), 32'd0);

      // over-length frame
      pulse_start();
      check("len_err_cleared", 32'(err_code_a), 32'd0);
      w0 = wcount;
      send_byte(8'h01);
      send_byte(8'h01);
      valid = 1'b0;
      check("len_err",  32'(err_a), 32'd1);
      check("len_code", 32'(err_code_a), 32'd1);
      repeat (3) @(posedge clk);
      #1;
      check("len_no_we", 32'(wcount), 32'(w0));

      // empty frame
      pulse_start();
      send_frame(0, 8'h00, 1'b0);
      check("empty_done",  32'(done_a), 32'd1);
      check("empty_code",  32'(err_code_a), 32'd0);
      check("empty_no_we", 32'(wcount), 32'(w0));

      // start pulsed mid-DATA is ignored
      words[0] = 32'hDEAD_BEEF;
      pulse_start();
      send_frame(1, 8'h00, 1'b1);
      check("midstart_done", 32'(done_a), 32'd1);
      check("midstart_err",  32'(err_a), 32'd0);

      // stream stalls after two data bytes
      pulse_start();
      w0 = wcount;
      send_byte(8'h00);
      send_byte(8'h03);
      send_byte(8'hAA);
      send_byte(8'hBB);
      valid = 1'b0;
      n = 0;
      while (err_a !== 1'b1 && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("timeout_cycles", 32'(n), 32'd8);
      check("timeout_code",   32'(err_code_a), 32'd3);
      check("timeout_no_we",  32'(wcount), 32'(w0));

      // reset in the middle of the second word
      words[0] = 32'h1122_3344;
      pulse_start();
      exp_a.push_back({32'h0000_0000, words[0]});
      exp_b.push_back({32'h0000_0100, words[0]});
      send_byte(8'h00);
      send_byte(8'h02);
      send_byte(8'h11);
      send_byte(8'h22);
      send_byte(8'h33);
      send_byte(8'h44);
      send_byte(8'h55);
      rst = 1'b1;
      @(posedge clk);
      #1;
      valid = 1'b0;
      check_reset_outputs("midrst");
      rst = 1'b0;

      // load, then restart from DONE with a longer frame
      words[0] = 32'hCAFE_0001;
      pulse_start();
      send_frame(1, 8'h00, 1'b0);
      check("reload1_done", 32'(done_a), 32'd1);
      words[0] = 32'h0BAD_F00D;
      words[1] = 32'h1234_5678;
      words[2] = 32'hFFFF_0000;
      pulse_start();
      check("reload_hold_a", 32'(cpu_hold_a), 32'd1);
      check("reload_hold_b", 32'(cpu_hold_b), 32'd1);
      send_frame(3, 8'h00, 1'b0);
      check("reload2_done_b", 32'(done_b), 32'd1);
      check("reload2_hold_b", 32'(cpu_hold_b), 32'd0);
      check("reload2_err_b",  32'(err_b), 32'd0);

      repeat (2) @(posedge clk);
      #1;
      check("final_pending_a", 32'(exp_a.size()), 32'd0);
      check("final_pending_b", 32'(exp_b.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: run did not complete, observed hang expected finish");
      $fatal(1, "watchdog expired");
   end
endmodule
